// File: rtl/rs485_rx_framer_if.sv
// Byte-stream and host-drain signal bundle of the RS-485 receive framer.
// master = receiver/host side, slave = the framer.
interface rs485_rx_framer_if #(
    parameter int DEPTH_LOG2 = 4
) ();
    logic                  clken_i;
    logic [7:0]            din_8b_i;
    logic                  din_valid_i;
    logic                  rden_i;
    logic                  clear_i;
    logic [7:0]            dout_8b_o;
    logic                  dout_valid_o;
    logic                  frame_ready_o;
    logic [DEPTH_LOG2:0]   frame_len_o;
    logic                  ovf_o;
    logic                  crc_ok_o;
    logic                  interrupt_o;

    modport master (
        output clken_i, din_8b_i, din_valid_i, rden_i, clear_i,
        input  dout_8b_o, dout_valid_o, frame_ready_o, frame_len_o, ovf_o, crc_ok_o, interrupt_o
    );

    modport slave (
        input  clken_i, din_8b_i, din_valid_i, rden_i, clear_i,
        output dout_8b_o, dout_valid_o, frame_ready_o, frame_len_o, ovf_o, crc_ok_o, interrupt_o
    );
endinterface

// File: rtl/rs485_rx_framer.sv
// Groups RS-485 bytes into silence-delimited frames, buffers them and lets the host drain them.
// Optional CRC-16/Modbus check built when RS485_RX_FRAMER_CRC_EN is defined.
module rs485_rx_framer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int GAP_TICKS  = 560
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    rs485_rx_framer_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0]         CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]         CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = CNT_ONE[DEPTH_LOG2-1:0];
    localparam logic [15:0]           GAP_LAST = 16'(GAP_TICKS - 32'sd1);
    localparam logic [15:0]           GAP_MAX  = 16'(GAP_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_r;
    logic [7:0]            mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic [CW-1:0]         frame_len_r;
    logic [15:0]           gap_r;
    logic [7:0]            dout_r;
    logic                  dout_valid_r;
    logic                  frame_ready_r;
    logic                  ovf_r;
    logic                  irq_r;

    logic full_s;
    logic empty_s;
    logic wr_en_s;
    logic rd_en_s;
    logic last_pop_s;

    // FIFO status and the accept/pop decisions; clear_i masks both.
    always_comb begin
        full_s     = (count_r == CNT_FULL);
        empty_s    = (count_r == CNT_ZERO);
        wr_en_s    = 1'b0;
        rd_en_s    = 1'b0;
        if (bus.clear_i) begin
            wr_en_s = 1'b0;
            rd_en_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: wr_en_s = bus.din_valid_i;
                ST_RECV: wr_en_s = bus.din_valid_i && !full_s;
                ST_DONE: rd_en_s = bus.rden_i && !empty_s;
                default: begin
                    wr_en_s = 1'b0;
                    rd_en_s = 1'b0;
                end
            endcase
        end
        last_pop_s = rd_en_s && (count_r == CNT_ONE);
    end

    // Byte storage; contents need no reset because pointers gate every read.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= bus.din_8b_i;
        end
    end

    // Frame FSM with FIFO pointers, gap timer and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r       <= ST_IDLE;
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            count_r       <= CNT_ZERO;
            frame_len_r   <= CNT_ZERO;
            gap_r         <= 16'h0000;
            dout_r        <= 8'h00;
            dout_valid_r  <= 1'b0;
            frame_ready_r <= 1'b0;
            ovf_r         <= 1'b0;
            irq_r         <= 1'b0;
        end else if (bus.clear_i) begin
            state_r       <= ST_IDLE;
            wr_ptr_r      <= PTR_ZERO;
            rd_ptr_r      <= PTR_ZERO;
            count_r       <= CNT_ZERO;
            frame_len_r   <= CNT_ZERO;
            gap_r         <= 16'h0000;
            dout_valid_r  <= 1'b0;
            frame_ready_r <= 1'b0;
            ovf_r         <= 1'b0;
            irq_r         <= 1'b0;
        end else begin
            irq_r        <= 1'b0;
            dout_valid_r <= 1'b0;

            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
                count_r  <= count_r + CNT_ONE;
            end else if (rd_en_s) begin
                rd_ptr_r     <= rd_ptr_r + PTR_ONE;
                count_r      <= count_r - CNT_ONE;
                dout_r       <= mem_r[rd_ptr_r];
                dout_valid_r <= 1'b1;
            end else begin
                count_r <= count_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (bus.din_valid_i) begin
                        frame_len_r <= CNT_ONE;
                        gap_r       <= 16'h0000;
                        state_r     <= ST_RECV;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RECV: begin
                    // A byte landing on the final silence tick keeps the frame open.
                    if (bus.din_valid_i) begin
                        gap_r <= 16'h0000;
                        if (full_s) begin
                            ovf_r <= 1'b1;
                        end else begin
                            frame_len_r <= frame_len_r + CNT_ONE;
                        end
                    end else if (bus.clken_i) begin
                        if (gap_r >= GAP_LAST) begin
                            gap_r   <= GAP_MAX;
                            state_r <= ST_DONE;
                            irq_r   <= 1'b1;
                        end else begin
                            gap_r <= gap_r + 16'h0001;
                        end
                    end else begin
                        gap_r <= gap_r;
                    end
                end
                ST_DONE: begin
                    if (bus.din_valid_i) begin
                        ovf_r <= 1'b1;
                    end else begin
                        ovf_r <= ovf_r;
                    end
                    if (last_pop_s) begin
                        state_r       <= ST_IDLE;
                        frame_ready_r <= 1'b0;
                        frame_len_r   <= CNT_ZERO;
                        gap_r         <= 16'h0000;
                    end else begin
                        frame_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r       <= ST_IDLE;
                    frame_ready_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef RS485_RX_FRAMER_CRC_EN
    logic [15:0] crc_r;
    logic [15:0] crc_seed_s;
    logic [15:0] crc_next_s;
    logic        crc_ok_r;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            if (c[0]) begin
                c = (c >> 1'b1) ^ 16'hA001;
            end else begin
                c = c >> 1'b1;
            end
        end
        return c;
    endfunction

    // The byte that opens a frame is folded into a fresh 0xFFFF seed.
    always_comb begin
        if (state_r == ST_IDLE) begin
            crc_seed_s = 16'hFFFF;
        end else begin
            crc_seed_s = crc_r;
        end
        crc_next_s = crc16_byte(crc_seed_s, bus.din_8b_i);
    end

    // CRC accumulator over accepted bytes and the residue check shown while a frame is held.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            crc_r    <= 16'hFFFF;
            crc_ok_r <= 1'b0;
        end else if (bus.clear_i) begin
            crc_r    <= 16'hFFFF;
            crc_ok_r <= 1'b0;
        end else begin
            if (wr_en_s) begin
                crc_r <= crc_next_s;
            end else begin
                crc_r <= crc_r;
            end
            if ((state_r == ST_DONE) && !last_pop_s) begin
                crc_ok_r <= (crc_r == 16'h0000);
            end else begin
                crc_ok_r <= 1'b0;
            end
        end
    end

    assign bus.crc_ok_o = crc_ok_r;
`else
    assign bus.crc_ok_o = 1'b1;
`endif

    assign bus.dout_8b_o     = dout_r;
    assign bus.dout_valid_o  = dout_valid_r;
    assign bus.frame_ready_o = frame_ready_r;
    assign bus.frame_len_o   = frame_len_r;
    assign bus.ovf_o         = ovf_r;
    assign bus.interrupt_o   = irq_r;
endmodule

// File: tb/tb_rs485_rx_framer.sv
// Self-checking bench for rs485_rx_framer: directed frame table, corner sequences and
// randomized frames, all compared against a queue-based reference model every cycle.
module tb_rs485_rx_framer;
    localparam int DL2    = 4;
    localparam int DEPTH  = 16;
    localparam int GAP    = 560;
    localparam int P_IDLE = 0;
    localparam int P_RECV = 1;
    localparam int P_DONE = 2;
`ifdef RS485_RX_FRAMER_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    rs485_rx_framer_if #(.DEPTH_LOG2(DL2)) bus ();

    rs485_rx_framer #(.DEPTH_LOG2(DL2), .GAP_TICKS(GAP)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int irq_cnt     = 0;

    // reference model: frame contents as queues, silence as a tick count
    logic [7:0] q[$];
    logic [7:0] frame[$];
    int         ph;
    int         sil;
    int         e_len;
    bit         e_ready, e_ovf, e_irq, e_dv, e_crc;
    logic [7:0] e_dout;

    typedef struct {
        int               n;
        logic [0:16][7:0] b;
        int               exp_len;
        bit               exp_ovf;
        bit               exp_crc;
    } frame_vec_t;

    frame_vec_t tbl[3];

    function automatic logic [15:0] crc16(input logic [7:0] bq[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (bq[i]) begin
            c = c ^ {8'h00, bq[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
            end
        end
        return c;
    endfunction

    function automatic bit coin(input int k);
        return $urandom_range(0, k - 1) == 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        frame.delete();
        ph      = P_IDLE;
        sil     = 0;
        e_len   = 0;
        e_ready = 1'b0;
        e_ovf   = 1'b0;
        e_irq   = 1'b0;
        e_dv    = 1'b0;
        e_dout  = 8'h00;
        e_crc   = !CRC_ON;
    endtask

    task automatic model_step(input bit ce, input bit dv, input logic [7:0] d, input bit rd, input bit clr);
        e_dv  = 1'b0;
        e_irq = 1'b0;
        if (clr) begin
            q.delete();
            frame.delete();
            ph      = P_IDLE;
            sil     = 0;
            e_len   = 0;
            e_ready = 1'b0;
            e_ovf   = 1'b0;
        end else if (ph == P_IDLE) begin
            if (dv) begin
                q.delete();
                frame.delete();
                q.push_back(d);
                frame.push_back(d);
                e_len = 1;
                sil   = 0;
                ph    = P_RECV;
            end
        end else if (ph == P_RECV) begin
            if (dv) begin
                sil = 0;
                if (q.size() < DEPTH) begin
                    q.push_back(d);
                    frame.push_back(d);
                    e_len++;
                end else begin
                    e_ovf = 1'b1;
                end
            end else if (ce) begin
                sil++;
                if (sil == GAP) begin
                    ph    = P_DONE;
                    e_irq = 1'b1;
                end
            end
        end else begin
            if (dv) e_ovf = 1'b1;
            e_ready = 1'b1;
            if (rd && q.size() > 0) begin
                e_dout = q.pop_front();
                e_dv   = 1'b1;
                if (q.size() == 0) begin
                    ph      = P_IDLE;
                    e_ready = 1'b0;
                    e_len   = 0;
                end
            end
        end
        e_crc = CRC_ON ? (e_ready && (crc16(frame) == 16'h0000)) : 1'b1;
    endtask

    task automatic check_outputs();
        chk("frame_ready", int'(bus.frame_ready_o), int'(e_ready));
        chk("frame_len",   int'(bus.frame_len_o),   e_len);
        chk("ovf",         int'(bus.ovf_o),         int'(e_ovf));
        chk("interrupt",   int'(bus.interrupt_o),   int'(e_irq));
        chk("crc_ok",      int'(bus.crc_ok_o),      int'(e_crc));
        chk("dout_valid",  int'(bus.dout_valid_o),  int'(e_dv));
        if (e_dv) chk("dout", int'(bus.dout_8b_o), int'(e_dout));
    endtask

    task automatic cyc(input bit ce, input bit dv, input logic [7:0] d, input bit rd, input bit clr);
        bus.clken_i     = ce;
        bus.din_valid_i = dv;
        bus.din_8b_i    = d;
        bus.rden_i      = rd;
        bus.clear_i     = clr;
        @(posedge clk);
        #1;
        model_step(ce, dv, d, rd, clr);
        if (bus.interrupt_o) irq_cnt++;
        check_outputs();
        bus.clken_i     = 1'b0;
        bus.din_valid_i = 1'b0;
        bus.rden_i      = 1'b0;
        bus.clear_i     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        int k;
        k = $urandom_range(0, 3);
        for (int i = 0; i < k; i++) begin
            cyc(coin(2), 1'b0, 8'h00, (ph != P_DONE) && coin(4), 1'b0);
        end
        cyc(coin(2), 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic silence(input int n);
        int t;
        bit ce;
        t = 0;
        for (int g = 0; g < n * 8 + 64 && t < n; g++) begin
            ce = ($urandom_range(0, 3) != 0);
            cyc(ce, 1'b0, 8'h00, 1'b0, 1'b0);
            if (ce) t++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, int'(bus.frame_ready_o), 0);
        chk({tag, "_len"},   int'(bus.frame_len_o),   0);
        chk({tag, "_ovf"},   int'(bus.ovf_o),         0);
        chk({tag, "_irq"},   int'(bus.interrupt_o),   0);
        chk({tag, "_dv"},    int'(bus.dout_valid_o),  0);
        chk({tag, "_dout"},  int'(bus.dout_8b_o),     0);
        chk({tag, "_crc"},   int'(bus.crc_ok_o),      CRC_ON ? 0 : 1);
    endtask

    initial begin
        logic [7:0]  fb[$];
        logic [7:0]  tmp[$];
        logic [15:0] c16;
        int          n;

        bus.clken_i     = 1'b0;
        bus.din_valid_i = 1'b0;
        bus.din_8b_i    = 8'h00;
        bus.rden_i      = 1'b0;
        bus.clear_i     = 1'b0;
        rst_n           = 1'b0;
        model_reset();

        tbl[0].n = 8;
        tbl[0].b = {8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A, {9{8'h00}}};
        tbl[0].exp_len = 8;  tbl[0].exp_ovf = 1'b0; tbl[0].exp_crc = 1'b1;
        tbl[1].n = 8;
        tbl[1].b = {8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0B, {9{8'h00}}};
        tbl[1].exp_len = 8;  tbl[1].exp_ovf = 1'b0; tbl[1].exp_crc = !CRC_ON;
        tbl[2].n = 17;
        tmp.delete();
        for (int i = 0; i < 17; i++) begin
            tbl[2].b[i] = 8'(i * 7 + 1);
            if (i < 16) tmp.push_back(tbl[2].b[i]);
        end
        tbl[2].exp_len = 16; tbl[2].exp_ovf = 1'b1;
        tbl[2].exp_crc = CRC_ON ? (crc16(tmp) == 16'h0000) : 1'b1;

        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // directed frame table
        for (int r = 0; r < 3; r++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            irq_cnt = 0;
            for (int i = 0; i < tbl[r].n; i++) send_byte(tbl[r].b[i]);
            silence(GAP);
            cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            chk("tbl_irq_count", irq_cnt, 1);
            chk("tbl_ready", int'(bus.frame_ready_o), 1);
            chk("tbl_len", int'(bus.frame_len_o), tbl[r].exp_len);
            chk("tbl_ovf", int'(bus.ovf_o), int'(tbl[r].exp_ovf));
            chk("tbl_crc_ok", int'(bus.crc_ok_o), int'(tbl[r].exp_crc));
            for (int i = 0; i < tbl[r].exp_len; i++) begin
                cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
                chk("tbl_dout_valid", int'(bus.dout_valid_o), 1);
                chk("tbl_dout", int'(bus.dout_8b_o), int'(tbl[r].b[i]));
            end
            chk("tbl_ready_after_drain", int'(bus.frame_ready_o), 0);
            cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            chk("tbl_ovf_cleared", int'(bus.ovf_o), 0);
        end

        // byte on the final silence tick keeps the frame open
        irq_cnt = 0;
        send_byte(8'hA1);
        send_byte(8'hA2);
        silence(GAP - 1);
        cyc(1'b1, 1'b1, 8'hA3, 1'b0, 1'b0);
        chk("final_tick_no_irq", irq_cnt, 0);
        chk("final_tick_len", int'(bus.frame_len_o), 3);
        silence(GAP - 1);
        chk("gap_restart_no_irq", irq_cnt, 0);
        silence(1);
        chk("gap_restart_irq", irq_cnt, 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("gap_restart_ready", int'(bus.frame_ready_o), 1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("gap_restart_last_byte", int'(bus.dout_8b_o), 8'hA3);

        // overrun while a frame is held, then clear
        for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i));
        silence(GAP);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0);
        chk("done_overrun_ovf", int'(bus.ovf_o), 1);
        chk("done_overrun_len", int'(bus.frame_len_o), 4);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("done_overrun_byte0", int'(bus.dout_8b_o), 8'hC0);
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("done_overrun_byte1", int'(bus.dout_8b_o), 8'hC1);
        cyc(1'b0, 1'b1, 8'h77, 1'b1, 1'b1);
        chk("clear_ovf", int'(bus.ovf_o), 0);
        chk("clear_ready", int'(bus.frame_ready_o), 0);
        chk("clear_len", int'(bus.frame_len_o), 0);
        chk("clear_no_pop", int'(bus.dout_valid_o), 0);

        // reset in the middle of a frame
        send_byte(8'h5A);
        chk("after_clear_len", int'(bus.frame_len_o), 1);
        send_byte(8'h5B);
        send_byte(8'h5C);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midframe_reset");
        model_reset();
        irq_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        silence(GAP + 20);
        chk("midframe_reset_no_irq", irq_cnt, 0);
        send_byte(8'h11);
        chk("midframe_reset_next_len", int'(bus.frame_len_o), 1);
        silence(GAP);

        // randomized frames
        for (int f = 0; f < 12; f++) begin
            fb.delete();
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
            if (coin(2) && n <= 14) begin
                c16 = crc16(fb);
                fb.push_back(c16[7:0]);
                fb.push_back(c16[15:8]);
            end
            foreach (fb[i]) send_byte(fb[i]);
            silence(GAP);
            for (int c = 0; c < 120 && ph != P_IDLE; c++) begin
                cyc(coin(2), coin(10), 8'($urandom), coin(2), coin(60));
            end
            if (coin(2)) cyc(1'b0, coin(2), 8'($urandom), coin(2), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rs485_rx_framer.md
Name: rs485_rx_framer

Overview:
- Sits directly downstream of the RS-485 byte receiver and consumes its 8-bit byte plus one-cycle valid strobe.
- Groups received bytes into frames using a Modbus-RTU-style silence gap, measured in receiver sample ticks.
- Buffers each frame in a small FIFO and raises a one-cycle interrupt when a frame is complete.
- The control/register block then drains the frame byte by byte.

Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 bytes (default 16).
- GAP_TICKS, 560: clken_i ticks of line silence that end a frame (3.5 chars x 160 ticks). Legal range 1..65535.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- clken_i  in  1  receiver sample-tick enable, same tick that drives the byte receiver.
- din_8b_i  in  8  received byte.
- din_valid_i  in  1  one-cycle strobe; din_8b_i is valid in this cycle.
- rden_i  in  1  pop one byte of the completed frame.
- clear_i  in  1  flush FIFO, clear flags, return to IDLE.
- dout_8b_o  out  8  popped byte.
- dout_valid_o  out  1  one-cycle strobe, dout_8b_o is valid.
- frame_ready_o  out  1  level: a complete frame is held.
- frame_len_o  out  DEPTH_LOG2+1  bytes stored in the current frame.
- ovf_o  out  1  sticky: a byte was dropped.
- crc_ok_o  out  1  frame CRC check result (see Optional Feature).
- interrupt_o  out  1  one-cycle pulse on frame completion.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous, active-low on rst_n_i.
- Reset values: all outputs 0 (crc_ok_o = 1 when the CRC option is compiled out). FIFO pointers, frame_len, gap counter = 0. State = IDLE.
- Gap counter: 16 bits. Counts clken_i ticks and saturates at GAP_TICKS.
- IDLE:
  - din_valid_i: write byte, frame_len = 1, gap = 0, go to RECV.
  - rden_i is ignored.
- RECV:
  - Each clken_i tick: gap + 1.
  - din_valid_i: gap = 0; write byte if FIFO not full, frame_len + 1.
  - din_valid_i with FIFO full: drop the byte, set ovf_o, gap still cleared.
  - When gap == GAP_TICKS: go to DONE, interrupt_o = 1 for exactly one cycle, frame_ready_o = 1 from the next cycle.
  - A byte and the final tick in the same cycle: the byte wins. It is accepted, gap resets, and the state stays RECV.
  - rden_i is ignored.
- DONE:
  - rden_i with FIFO not empty: pop. dout_8b_o and dout_valid_o are registered and appear 1 cycle after rden_i. frame_len is unchanged.
  - rden_i with FIFO empty: no pop, no dout_valid_o.
  - When the last byte is popped: go to IDLE; frame_ready_o falls in the same cycle dout_valid_o rises; frame_len clears.
  - din_valid_i: byte dropped, ovf_o set (receiver overrun while the host holds a frame).
- clear_i: highest priority in every state. Pointers, frame_len, gap and ovf_o clear, state goes to IDLE, and any simultaneous din_valid_i or rden_i is ignored.
- Frame of exactly 2^DEPTH_LOG2 bytes: fits with no overflow, and frame_len_o = 2^DEPTH_LOG2.
- Back-to-back rden_i: one byte per cycle. Pointers wrap modulo the depth.
- Reset mid-frame: contents are discarded and no interrupt is issued.

Optional Feature:
- Macro: RS485_RX_FRAMER_CRC_EN.
- Defined:
  - A CRC-16/Modbus register (reflected poly 0xA001, init 0xFFFF) is updated combinationally, 8 bit-steps, in the cycle each byte is accepted into the FIFO.
  - The register reinitialises to 0xFFFF on the IDLE->RECV byte and on clear_i.
  - crc_ok_o = (crc == 0x0000) while frame_ready_o = 1, and 0 otherwise.
  - Dropped bytes are not included in the CRC.
- Undefined: no CRC logic is built, and crc_ok_o is tied to 1.

Test Plan:
- Send 01 03 00 00 00 01 84 0A at normal spacing, then hold silence 560 ticks -> one interrupt_o pulse; frame_ready_o = 1, frame_len_o = 8, crc_ok_o = 1 (with the macro); 8 rden_i pulses return the bytes in order; frame_ready_o = 0 after the 8th.
- Same frame with the last byte 0B -> frame_len_o = 8 and crc_ok_o = 0 (with the macro), crc_ok_o = 1 without it.
- Send 17 bytes with DEPTH_LOG2 = 4 -> frame_len_o = 16, ovf_o = 1, and reading returns the first 16 bytes.
- Byte arriving on the 560th tick -> no interrupt; the frame continues and ends 560 ticks after that byte.
- Byte arrives while in DONE -> ovf_o = 1 and the FIFO contents are unchanged. Then clear_i -> ovf_o = 0, frame_ready_o = 0, state IDLE.
- Assert rst_n_i low after 3 bytes while in RECV -> all outputs 0 and no interrupt. The next frame starts at frame_len_o = 1.
